conv2d_stream_systolic: RTL and testbench

- Parametrised, streaming successor to the fixed 3x3-filter / 4x4-image systolic convolution engine.
- Accepts a KxK filter, then an IMG_H x IMG_W image in raster order, through valid/ready handshakes.
- Emits the valid (no-padding) 2-D correlation results in raster order through a backpressured output port.
- Uses K-1 line buffers, a KxK window register, a KxK multiplier array and a registered adder tree, so the image is never held in full.

---
 rtl/conv2d_stream_systolic.sv | 170 +++++++++++++++++
 tb/tb_conv2d_stream_systolic.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_systolic.sv
// Streaming KxK valid-window correlation: line buffers + window + product/sum stages, 2-cycle accept-to-output latency.
// A held output (out_valid && !out_ready) freezes every stage and drops pix_ready, so nothing is lost or repeated.
module conv2d_stream_systolic #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int OUT_W  = 8,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reuse_coef,
    input  logic              coef_valid,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_ready,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int NC    = K * K;
    localparam int ACC_W = 2 * DATA_W + $clog2(NC);
    localparam int CIW   = $clog2(NC);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]   coef [NC];
    logic [CIW-1:0]      coef_idx;
    logic [XW-1:0]       col;
    logic [YW-1:0]       row;
    logic [DATA_W-1:0]   lb   [K-1][IMG_W];
    logic [DATA_W-1:0]   win  [K][K];
    logic [2*DATA_W-1:0] prod [K][K];
    logic                win_vld, win_last, prod_vld, prod_last;
    logic                stall, coef_acc, pix_acc, frame_start;
    logic                last_coef, last_pix, win_done, drain_done;
    logic [ACC_W-1:0]    sum_c;
    logic [ACC_W+OUT_W-1:0] ext_c;
    logic [OUT_W-1:0]    red_c;

    assign stall       = out_valid && !out_ready;
    assign coef_acc    = coef_valid && coef_ready;
    assign pix_acc     = pix_valid && pix_ready;
    assign frame_start = (state == IDLE) && start;
    assign last_coef   = int'(coef_idx) == NC - 1;
    assign last_pix    = (int'(row) == IMG_H - 1) && (int'(col) == IMG_W - 1);
    assign win_done    = (int'(row) >= K - 1) && (int'(col) >= K - 1);
    assign drain_done  = !win_vld && !prod_vld && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        coef_ready = 1'b0;
        pix_ready  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nx = reuse_coef ? RUN : LOAD;
            LOAD: begin
                coef_ready = 1'b1;
                if (coef_valid && last_coef) state_nx = RUN;
            end
            RUN: begin
                pix_ready = !stall;
                if (pix_valid && !stall && last_pix) state_nx = DRAIN;
            end
            DRAIN: if (drain_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_idx <= '0;
            row      <= '0;
            col      <= '0;
            done     <= 1'b0;
            for (int i = 0; i < NC; i++) coef[i] <= '0;
        end else begin
            done <= (state == DRAIN) && drain_done;
            if (frame_start) begin
                coef_idx <= '0;
                row      <= '0;
                col      <= '0;
            end
            if (coef_acc) begin
                coef[coef_idx] <= coef_data;
                coef_idx       <= last_coef ? '0 : coef_idx + CIW'(1);
            end
            if (pix_acc) begin
                if (int'(col) == IMG_W - 1) begin
                    col <= '0;
                    row <= row + YW'(1);
                end else begin
                    col <= col + XW'(1);
                end
            end
        end
    end

    // Line buffer i holds row (r-K+1+i) of the image; each accepted pixel pushes one column into the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K - 1; i++)
                for (int x = 0; x < IMG_W; x++) lb[i][x] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win[i][j] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < K - 1; i++)
                for (int x = 0; x < IMG_W; x++) lb[i][x] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win[i][j] <= '0;
        end else if (pix_acc) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
            for (int i = 0; i < K - 1; i++) win[i][K-1] <= lb[i][col];
            win[K-1][K-1] <= pix_data;
            for (int i = 0; i < K - 2; i++) lb[i][col] <= lb[i+1][col];
            lb[K-2][col] <= pix_data;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) sum_c = sum_c + ACC_W'(prod[i][j]);
        ext_c = (ACC_W + OUT_W)'(sum_c);
        red_c = ext_c[OUT_W-1:0];
        if (SAT != 0 && (ext_c >> OUT_W) != '0) red_c = '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_vld   <= 1'b0;
            win_last  <= 1'b0;
            prod_vld  <= 1'b0;
            prod_last <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) prod[i][j] <= '0;
        end else if (!stall) begin
            win_vld   <= pix_acc && win_done;
            win_last  <= pix_acc && last_pix;
            prod_vld  <= win_vld;
            prod_last <= win_last;
            if (win_vld)
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        prod[i][j] <= (2*DATA_W)'(win[i][j]) * (2*DATA_W)'(coef[i*K+j]);
            out_valid <= prod_vld;
            out_last  <= prod_vld && prod_last;
            if (prod_vld) out_data <= red_c;
        end
    end
endmodule

// File: tb/tb_conv2d_stream_systolic.sv
// Bench for conv2d_stream_systolic: saturating and wrapping 4x4 instances share stimulus; a 6x5 instance runs a random frame.
module tb_conv2d_stream_systolic;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, reuse_coef, coef_valid, pix_valid, out_ready;
    logic [7:0] coef_data, pix_data;
    logic       coef_ready, pix_ready, out_valid, out_last, busy, done;
    logic [7:0] out_data;
    logic       w_coef_ready, w_pix_ready, w_out_valid, w_out_last, w_busy, w_done;
    logic [7:0] w_out_data;
    logic       b_start, b_reuse, b_coef_valid, b_pix_valid, b_out_ready;
    logic [7:0] b_coef_data, b_pix_data, b_out_data;
    logic       b_coef_ready, b_pix_ready, b_out_valid, b_out_last, b_busy, b_done;

    conv2d_stream_systolic #(.DATA_W(8), .K(3), .IMG_W(4), .IMG_H(4), .OUT_W(8), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_coef(reuse_coef),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done));

    conv2d_stream_systolic #(.DATA_W(8), .K(3), .IMG_W(4), .IMG_H(4), .OUT_W(8), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .reuse_coef(reuse_coef),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(w_coef_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(w_pix_ready),
        .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
        .out_last(w_out_last), .busy(w_busy), .done(w_done));

    conv2d_stream_systolic #(.DATA_W(8), .K(3), .IMG_W(6), .IMG_H(5), .OUT_W(8), .SAT(1)) dut_big (
        .clk(clk), .rst(rst), .start(b_start), .reuse_coef(b_reuse),
        .coef_valid(b_coef_valid), .coef_data(b_coef_data), .coef_ready(b_coef_ready),
        .pix_valid(b_pix_valid), .pix_data(b_pix_data), .pix_ready(b_pix_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .out_last(b_out_last), .busy(b_busy), .done(b_done));

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic             reuse;
        logic             toggle;
        logic             gaps;
        logic [8:0][7:0]  coef;
        logic [15:0][7:0] pix;
        logic [3:0][7:0]  exp;
        logic [3:0][7:0]  exp_wrap;
    } vec_t;

    exp_t q_main[$], q_wrap[$], q_big[$];
    exp_t me, we, be;
    int   checks = 0, errors = 0;
    int   done_cnt = 0, big_cnt = 0, big_done_cnt = 0;
    bit   toggle_mode = 1'b0;
    bit   held_vld = 1'b0;
    logic [7:0] held;

    logic [7:0] basic_coef [9]  = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
    logic [7:0] basic_pix  [16] = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
    logic [7:0] basic_exp  [4]  = '{67, 74, 34, 59};
    vec_t tab [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " out_valid"},  int'(out_valid), 0);
        chk({tag, " out_data"},   int'(out_data), 0);
        chk({tag, " out_last"},   int'(out_last), 0);
        chk({tag, " busy"},       int'(busy), 0);
        chk({tag, " done"},       int'(done), 0);
        chk({tag, " coef_ready"}, int'(coef_ready), 0);
        chk({tag, " pix_ready"},  int'(pix_ready), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_mode ? ~out_ready : 1'b1;
        end
    end

    // Scoreboard side: pop expectations on every output handshake.
    always @(negedge clk) begin
        if (done)   done_cnt++;
        if (b_done) big_done_cnt++;
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q_main.size() == 0) fail_now("main unexpected output");
                else begin
                    me = q_main.pop_front();
                    chk("main out_data", int'(out_data), int'(me.data));
                    chk("main out_last", int'(out_last), int'(me.last));
                end
            end
            if (w_out_valid && out_ready) begin
                if (q_wrap.size() == 0) fail_now("wrap unexpected output");
                else begin
                    we = q_wrap.pop_front();
                    chk("wrap out_data", int'(w_out_data), int'(we.data));
                    chk("wrap out_last", int'(w_out_last), int'(we.last));
                end
            end
            if (out_valid && !out_ready) begin
                chk("pix_ready during stall", int'(pix_ready), 0);
                if (held_vld) chk("out_data stable in stall", int'(out_data), int'(held));
                held_vld = 1'b1;
                held     = out_data;
            end else begin
                held_vld = 1'b0;
            end
            if (b_out_valid && b_out_ready) begin
                big_cnt++;
                if (q_big.size() == 0) fail_now("big unexpected output");
                else begin
                    be = q_big.pop_front();
                    chk("big out_data", int'(b_out_data), int'(be.data));
                    chk("big out_last", int'(b_out_last), int'(be.last));
                end
            end
        end
    end

    task automatic send_coef(input logic [7:0] d, input bit junk);
        int n = 0;
        bit ok = 1'b0;
        coef_valid = 1'b1;
        coef_data  = d;
        if (junk) begin
            pix_valid = 1'b1;
            pix_data  = 8'd200;
        end
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = coef_ready;
            @(posedge clk);
            #1;
            n++;
        end
        coef_valid = 1'b0;
        pix_valid  = 1'b0;
        if (!ok) fail_now("coef handshake timeout");
    endtask

    task automatic send_pix(input logic [7:0] d, input bit gaps, input bit reuse);
        int n = 0;
        bit ok = 1'b0;
        if (gaps) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b1;
        pix_data  = d;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = pix_ready;
            if (reuse) chk("coef_ready in reuse frame", int'(coef_ready), 0);
            @(posedge clk);
            #1;
            n++;
        end
        pix_valid = 1'b0;
        if (!ok) fail_now("pixel handshake timeout");
    endtask

    task automatic run_frame(input vec_t v, input bit junk_load, input bit start_run);
        int d0;
        int n = 0;
        toggle_mode = v.toggle;
        for (int k = 0; k < 4; k++) begin
            q_main.push_back('{data: v.exp[k], last: (k == 3)});
            q_wrap.push_back('{data: v.exp_wrap[k], last: (k == 3)});
        end
        d0 = done_cnt;
        start      = 1'b1;
        reuse_coef = v.reuse;
        @(posedge clk);
        #1;
        start      = 1'b0;
        reuse_coef = 1'b0;
        chk("busy after start", int'(busy), 1);
        chk("coef_ready after start", int'(coef_ready), v.reuse ? 0 : 1);
        if (!v.reuse)
            for (int i = 0; i < 9; i++) send_coef(v.coef[i], junk_load);
        for (int p = 0; p < 16; p++) begin
            if (start_run && p == 5) start = 1'b1;
            send_pix(v.pix[p], v.gaps, v.reuse);
            if (start_run && p == 5) begin
                start = 1'b0;
                chk("coef_ready after start in RUN", int'(coef_ready), 0);
                chk("busy after start in RUN", int'(busy), 1);
            end
        end
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) fail_now("done pulse timeout");
        else begin
            repeat (3) @(posedge clk);
            #1;
            chk("single done pulse", done_cnt, d0 + 1);
            chk("busy after done", int'(busy), 0);
            chk("main results outstanding", q_main.size(), 0);
            chk("wrap results outstanding", q_wrap.size(), 0);
        end
        toggle_mode = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bc [9];
        logic [7:0] bp [30];
        int s, d0, c0, n;

        rst = 1'b1; start = 1'b0; reuse_coef = 1'b0;
        coef_valid = 1'b0; coef_data = '0; pix_valid = 1'b0; pix_data = '0;
        b_start = 1'b0; b_reuse = 1'b0; b_coef_valid = 1'b0; b_pix_valid = 1'b0;
        b_coef_data = '0; b_pix_data = '0; b_out_ready = 1'b1;

        for (int t = 0; t < 4; t++) begin
            tab[t] = '0;
            for (int i = 0; i < 9; i++)  tab[t].coef[i] = (t == 3) ? 8'd1 : basic_coef[i];
            for (int i = 0; i < 16; i++) tab[t].pix[i]  = (t == 3) ? 8'd255 : basic_pix[i];
            for (int k = 0; k < 4; k++) begin
                tab[t].exp[k]      = (t == 3) ? 8'd255 : basic_exp[k];
                tab[t].exp_wrap[k] = (t == 3) ? 8'd247 : basic_exp[k];
            end
        end
        tab[1].toggle = 1'b1;
        tab[1].gaps   = 1'b1;
        tab[2].reuse  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) run_frame(tab[t], 1'b0, 1'b0);

        // Reset in the middle of a frame, before any window completes.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) send_coef(basic_coef[i], 1'b0);
        for (int p = 0; p < 8; p++) send_pix(basic_pix[p], 1'b0, 1'b0);
        chk("busy before mid-frame reset", int'(busy), 1);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check_idle("mid-frame reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no done after reset", done_cnt, d0);
        chk("no output after reset", q_main.size(), 0);
        run_frame(tab[0], 1'b0, 1'b0);

        run_frame(tab[0], 1'b1, 1'b1);

        // Random 6x5 frame on the wider instance against a direct model.
        for (int i = 0; i < 9; i++)  bc[i] = 8'($urandom_range(0, 3));
        for (int i = 0; i < 30; i++) bp[i] = 8'($urandom_range(0, 15));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(bc[i*3+j]) * int'(bp[(r+i)*6 + c + j]);
                q_big.push_back('{data: 8'((s > 255) ? 255 : s), last: (r == 2 && c == 3)});
            end
        c0 = big_cnt;
        d0 = big_done_cnt;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_coef_valid = 1'b1;
            b_coef_data  = bc[i];
            n = 0;
            while (!b_coef_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            #1;
        end
        b_coef_valid = 1'b0;
        for (int p = 0; p < 30; p++) begin
            b_pix_valid = 1'b0;
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            b_pix_valid = 1'b1;
            b_pix_data  = bp[p];
            n = 0;
            while (!b_pix_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            #1;
        end
        b_pix_valid = 1'b0;
        n = 0;
        while (big_done_cnt == d0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (big_done_cnt == d0) fail_now("big done timeout");
        chk("big result count", big_cnt - c0, 12);
        chk("big results outstanding", q_big.size(), 0);
        chk("big busy after done", int'(b_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
